// File: rtl/bus_sram_slave.sv
// ============================================================================
// Module      : bus_sram_slave
// Description : Bus target wrapping a single-ported word-wide SRAM. Requests
//               are sampled on cs_/as_ low, held for WAIT_CYCLES wait states,
//               then acknowledged with a one-cycle active-low rdy_. rd_data is
//               zero outside the acknowledge cycle so it can be OR-ed onto the
//               shared read-data bus.
// Options     : BUS_SRAM_INIT_ZERO_EN - zero-fill the SRAM after reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_sram_slave #(
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_INIT = 2'd3
    } state_t;

`ifdef BUS_SRAM_INIT_ZERO_EN
    localparam state_t RESET_STATE = S_INIT;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    logic [DATA_W-1:0]     mem [DEPTH];

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;
    logic [DEPTH_LOG2-1:0] lat_addr;
    logic                  lat_rw;
    logic [DATA_W-1:0]     lat_data;

    logic                  sample;
    logic                  go_ack;
    logic [DEPTH_LOG2-1:0] acc_addr;
    logic                  acc_rw;
    logic [DATA_W-1:0]     acc_data;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [DATA_W-1:0]     mem_wdata;

`ifdef BUS_SRAM_INIT_ZERO_EN
    logic [DEPTH_LOG2-1:0] sweep;
`endif

    // Upper address bits are deliberately dropped: accesses alias modulo depth.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[ADDR_W-1:DEPTH_LOG2];

    // A zero-wait request enters ACK on its own sampling edge, so the access
    // must use the live bus inputs there; otherwise the latched copy is used.
    always_comb begin
        sample   = (state == S_IDLE) && !cs_ && !as_;
        go_ack   = (sample && (WAIT_CYCLES == 0)) ||
                   ((state == S_WAIT) && (cnt == 4'd1));
        acc_addr = lat_addr;
        acc_rw   = lat_rw;
        acc_data = lat_data;
        if (state == S_IDLE) begin
            acc_addr = addr[DEPTH_LOG2-1:0];
            acc_rw   = rw;
            acc_data = wr_data;
        end
        mem_we    = go_ack && !acc_rw;
        mem_waddr = acc_addr;
        mem_wdata = acc_data;
`ifdef BUS_SRAM_INIT_ZERO_EN
        if (state == S_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = sweep;
            mem_wdata = '0;
        end
`endif
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (sample) begin
                    cnt_nxt   = WAIT_LOAD;
                    state_nxt = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                state_nxt = S_IDLE;
            end
`ifdef BUS_SRAM_INIT_ZERO_EN
            S_INIT: begin
                if (sweep == '1) begin
                    state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state, request latch, acknowledge and read-data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RESET_STATE;
            cnt      <= 4'd0;
            lat_addr <= '0;
            lat_rw   <= 1'b0;
            lat_data <= '0;
            rdy_     <= 1'b1;
            rd_data  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdy_    <= !go_ack;
            rd_data <= (go_ack && acc_rw) ? mem[acc_addr] : '0;
            if (sample) begin
                lat_addr <= addr[DEPTH_LOG2-1:0];
                lat_rw   <= rw;
                lat_data <= wr_data;
            end
        end
    end

`ifdef BUS_SRAM_INIT_ZERO_EN
    // Zero-fill sweep address; restarts from 0 on every reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweep <= '0;
        end else if (state == S_INIT) begin
            sweep <= sweep + DEPTH_LOG2'(1);
        end
    end
`endif

    // SRAM write port; an edge seen while reset is held never commits.
    always_ff @(posedge clk) begin
        if (mem_we && rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_sram_slave.sv
// ============================================================================
// Module      : tb_bus_sram_slave
// Description : Directed bench for bus_sram_slave with three instances using
//               WAIT_CYCLES = 0, 1 and 3. Honours BUS_SRAM_INIT_ZERO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_sram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_b   [3];
    logic        as_b   [3];
    logic        rw_b   [3];
    logic        rdy_b  [3];
    logic [29:0] addr_b [3];
    logic [31:0] wd_b   [3];
    logic [31:0] rd_b   [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_sram_slave #(.ADDR_W(30), .DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .cs_(cs_b[0]), .as_(as_b[0]), .rw(rw_b[0]),
        .addr(addr_b[0]), .wr_data(wd_b[0]), .rd_data(rd_b[0]), .rdy_(rdy_b[0]));
    bus_sram_slave #(.ADDR_W(30), .DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .cs_(cs_b[1]), .as_(as_b[1]), .rw(rw_b[1]),
        .addr(addr_b[1]), .wr_data(wd_b[1]), .rd_data(rd_b[1]), .rdy_(rdy_b[1]));
    bus_sram_slave #(.ADDR_W(30), .DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .cs_(cs_b[2]), .as_(as_b[2]), .rw(rw_b[2]),
        .addr(addr_b[2]), .wr_data(wd_b[2]), .rd_data(rd_b[2]), .rdy_(rdy_b[2]));

    function automatic int wc(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            cs_b[i] = 1'b1; as_b[i] = 1'b1; rw_b[i] = 1'b1;
            addr_b[i] = '0; wd_b[i] = '0;
        end
    endtask

    // One complete transaction; checks the rdy_ timing and returns ack data.
    task automatic xfer(input int i, input logic r, input logic [29:0] a,
                        input logic [31:0] d, input string tag, output logic [31:0] got);
        int w;
        w = wc(i);
        got = '0;
        @(negedge clk);
        cs_b[i] = 1'b0; as_b[i] = 1'b0; rw_b[i] = r; addr_b[i] = a; wd_b[i] = d;
        @(posedge clk);
        for (int k = 0; k <= w; k++) begin
            @(negedge clk);
            checks++;
            if (k < w) begin
                if (rdy_b[i] !== 1'b1 || rd_b[i] !== 32'h0) begin
                    failures++;
                    $display("FAIL %s wait k=%0d: rdy_=%b rd_data=%h, expected rdy_=1 rd_data=0",
                             tag, k, rdy_b[i], rd_b[i]);
                end
            end else begin
                got = rd_b[i];
                if (rdy_b[i] !== 1'b0) begin
                    failures++;
                    $display("FAIL %s ack: rdy_=%b, expected 0", tag, rdy_b[i]);
                end
                cs_b[i] = 1'b1; as_b[i] = 1'b1;
            end
        end
        @(negedge clk);
        checks++;
        if (rdy_b[i] !== 1'b1 || rd_b[i] !== 32'h0) begin
            failures++;
            $display("FAIL %s post: rdy_=%b rd_data=%h, expected rdy_=1 rd_data=0",
                     tag, rdy_b[i], rd_b[i]);
        end
    endtask

    task automatic test_reset();
        logic [31:0] got;
        int n;
        rst = 1'b0;
        idle_all();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rdy_b[i] !== 1'b1 || rd_b[i] !== 32'h0) begin
                failures++;
                $display("FAIL reset inst%0d: rdy_=%b rd_data=%h, expected rdy_=1 rd_data=0",
                         i, rdy_b[i], rd_b[i]);
            end
        end
        rst = 1'b1;
`ifdef BUS_SRAM_INIT_ZERO_EN
        cs_b[1] = 1'b0; as_b[1] = 1'b0; rw_b[1] = 1'b1; addr_b[1] = 30'h7;
        n = 0;
        while (n < 1300) begin
            @(negedge clk);
            n++;
            if (rdy_b[1] === 1'b0) break;
        end
        checks++;
        if (n < 1026 || n >= 1300 || rd_b[1] !== 32'h0) begin
            failures++;
            $display("FAIL init_latency: cycles=%0d rd_data=%h, expected 1026..1299 cycles rd_data=0",
                     n, rd_b[1]);
        end
        cs_b[1] = 1'b1; as_b[1] = 1'b1;
        @(negedge clk);
        xfer(2, 1'b1, 30'h3FF, 32'h0, "init_read", got);
        checks++;
        if (got !== 32'h0) begin
            failures++;
            $display("FAIL init_read: rd_data=%h, expected 00000000", got);
        end
`else
        n = 0;
        got = '0;
        repeat (2) @(negedge clk);
`endif
    endtask

    task automatic test_basic();
        logic [31:0] got;
        xfer(1, 1'b0, 30'h005, 32'hDEADBEEF, "w1_write", got);
        checks++;
        if (got !== 32'h0) begin
            failures++; $display("FAIL w1_write_data: rd_data=%h, expected 0", got);
        end
        xfer(1, 1'b1, 30'h005, 32'h0, "w1_read", got);
        checks++;
        if (got !== 32'hDEADBEEF) begin
            failures++; $display("FAIL w1_read_data: rd_data=%h, expected deadbeef", got);
        end
    endtask

    task automatic test_alias();
        logic [31:0] got;
        xfer(1, 1'b0, 30'h400, 32'hA5A5A5A5, "alias_write", got);
        xfer(1, 1'b1, 30'h000, 32'h0, "alias_read0", got);
        checks++;
        if (got !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL alias_read0: rd_data=%h, expected a5a5a5a5", got);
        end
        xfer(1, 1'b1, 30'h800, 32'h0, "alias_read800", got);
        checks++;
        if (got !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL alias_read800: rd_data=%h, expected a5a5a5a5", got);
        end
        xfer(1, 1'b1, 30'h005, 32'h0, "alias_other", got);
        checks++;
        if (got !== 32'hDEADBEEF) begin
            failures++; $display("FAIL alias_other: rd_data=%h, expected deadbeef", got);
        end
    endtask

    // Two transactions on the zero-wait instance with as_ held low throughout.
    task automatic b2b(input logic r1, input logic [29:0] a1, input logic [31:0] d1,
                       input logic [31:0] e1, input logic [29:0] a2, input logic [31:0] e2,
                       input string tag);
        @(negedge clk);
        cs_b[0] = 1'b0; as_b[0] = 1'b0; rw_b[0] = r1; addr_b[0] = a1; wd_b[0] = d1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdy_b[0] !== 1'b0 || rd_b[0] !== e1) begin
            failures++;
            $display("FAIL %s first: rdy_=%b rd_data=%h, expected rdy_=0 rd_data=%h",
                     tag, rdy_b[0], rd_b[0], e1);
        end
        rw_b[0] = 1'b1; addr_b[0] = a2;
        @(negedge clk);
        checks++;
        if (rdy_b[0] !== 1'b1 || rd_b[0] !== 32'h0) begin
            failures++;
            $display("FAIL %s gap: rdy_=%b rd_data=%h, expected rdy_=1 rd_data=0",
                     tag, rdy_b[0], rd_b[0]);
        end
        @(negedge clk);
        checks++;
        if (rdy_b[0] !== 1'b0 || rd_b[0] !== e2) begin
            failures++;
            $display("FAIL %s second: rdy_=%b rd_data=%h, expected rdy_=0 rd_data=%h",
                     tag, rdy_b[0], rd_b[0], e2);
        end
        cs_b[0] = 1'b1; as_b[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy_b[0] !== 1'b1 || rd_b[0] !== 32'h0) begin
            failures++;
            $display("FAIL %s end: rdy_=%b rd_data=%h, expected rdy_=1 rd_data=0",
                     tag, rdy_b[0], rd_b[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        xfer(0, 1'b0, 30'h001, 32'h11, "w0_pre1", got);
        xfer(0, 1'b0, 30'h002, 32'h22, "w0_pre2", got);
        b2b(1'b1, 30'h001, 32'h0, 32'h11, 30'h002, 32'h22, "b2b_reads");
        b2b(1'b0, 30'h003, 32'h77, 32'h0, 30'h003, 32'h77, "b2b_wr_rd");
    endtask

    task automatic test_deselect();
        logic [31:0] got;
        @(negedge clk);
        cs_b[1] = 1'b1; as_b[1] = 1'b0; rw_b[1] = 1'b1; addr_b[1] = 30'h005;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (rdy_b[1] !== 1'b1 || rd_b[1] !== 32'h0) begin
                failures++;
                $display("FAIL deselect k=%0d: rdy_=%b rd_data=%h, expected rdy_=1 rd_data=0",
                         k, rdy_b[1], rd_b[1]);
            end
        end
        as_b[1] = 1'b1;
        // Deselect mid-wait on the 3-wait instance; the latched write completes.
        cs_b[2] = 1'b0; as_b[2] = 1'b0; rw_b[2] = 1'b0; addr_b[2] = 30'h020; wd_b[2] = 32'h5555AAAA;
        @(posedge clk);
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                cs_b[2] = 1'b1; as_b[2] = 1'b1; addr_b[2] = 30'h3C3; wd_b[2] = 32'hFFFFFFFF;
            end
            checks++;
            if (rdy_b[2] !== ((k == 3) ? 1'b0 : 1'b1)) begin
                failures++;
                $display("FAIL cs_drop k=%0d: rdy_=%b, expected %b", k, rdy_b[2], (k == 3) ? 1'b0 : 1'b1);
            end
        end
        @(negedge clk);
        checks++;
        if (rdy_b[2] !== 1'b1) begin
            failures++; $display("FAIL cs_drop_post: rdy_=%b, expected 1", rdy_b[2]);
        end
        xfer(2, 1'b1, 30'h020, 32'h0, "cs_drop_read", got);
        checks++;
        if (got !== 32'h5555AAAA) begin
            failures++; $display("FAIL cs_drop_read: rd_data=%h, expected 5555aaaa", got);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] got;
        logic [31:0] prior;
`ifdef BUS_SRAM_INIT_ZERO_EN
        prior = 32'h0;
`else
        prior = 32'hCAFEF00D;
`endif
        xfer(2, 1'b0, 30'h010, 32'hCAFEF00D, "rst_pre", got);
        @(negedge clk);
        cs_b[2] = 1'b0; as_b[2] = 1'b0; rw_b[2] = 1'b0; addr_b[2] = 30'h010; wd_b[2] = 32'h12345678;
        @(posedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_all();
        #1;
        checks++;
        if (rdy_b[2] !== 1'b1 || rd_b[2] !== 32'h0) begin
            failures++;
            $display("FAIL rst_wait: rdy_=%b rd_data=%h, expected rdy_=1 rd_data=0", rdy_b[2], rd_b[2]);
        end
        @(negedge clk);
        rst = 1'b1;
`ifdef BUS_SRAM_INIT_ZERO_EN
        repeat (1030) @(negedge clk);
`endif
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (rdy_b[2] !== 1'b1) begin
                failures++; $display("FAIL rst_abort k=%0d: rdy_=%b, expected 1", k, rdy_b[2]);
            end
        end
        xfer(2, 1'b1, 30'h010, 32'h0, "rst_read", got);
        checks++;
        if (got !== prior) begin
            failures++; $display("FAIL rst_read: rd_data=%h, expected %h", got, prior);
        end
    endtask

    task automatic test_reset_in_ack();
        logic [31:0] got;
        xfer(1, 1'b0, 30'h006, 32'h0BADF00D, "ack_pre", got);
        @(negedge clk);
        cs_b[1] = 1'b0; as_b[1] = 1'b0; rw_b[1] = 1'b1; addr_b[1] = 30'h006;
        @(posedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (rdy_b[1] !== 1'b0 || rd_b[1] !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL ack_read: rdy_=%b rd_data=%h, expected rdy_=0 rd_data=0badf00d",
                     rdy_b[1], rd_b[1]);
        end
        rst = 1'b0;
        idle_all();
        #1;
        checks++;
        if (rdy_b[1] !== 1'b1 || rd_b[1] !== 32'h0) begin
            failures++;
            $display("FAIL rst_ack: rdy_=%b rd_data=%h, expected rdy_=1 rd_data=0", rdy_b[1], rd_b[1]);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alias();
        test_back_to_back();
        test_deselect();
        test_reset_mid_wait();
        test_reset_in_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
